// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the core's load/store interface.
// Accepts one request at a time through valid/ready and performs RV32I
// byte/halfword/word accesses with lane steering and load extension.
// It returns a one-cycle response LATENCY+1 cycles after the accept.
// Malformed or out-of-range requests are flagged with rsp_err and have
// no effect on the array.
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  LAT_LOAD    = 4'(LATENCY);
   localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   // Control state
   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic        w_accept;
   logic        w_exec;

   // Captured request payload
   logic        r_we;
   logic [2:0]  r_size;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   // Operand view used on the execute edge
   logic        w_op_we;
   logic [2:0]  w_op_size;
   logic [31:0] w_op_addr;
   logic [31:0] w_op_wdata;
   logic [29:0] w_idx_full;
   logic [IDX_W-1:0] w_idx;
   logic [1:0]  w_lane;

   // Access decode
   logic        w_err;
   logic [3:0]  w_be;
   logic [31:0] w_wdata_lanes;
   logic [31:0] w_rd_word;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic        w_mem_we;

   logic [31:0] mem [DEPTH_WORDS];

   // State register and wait counter
   // NOTE: every clocked block uses non-blocking (<=) assignments so all
   // registers update from the same pre-edge values; blocking assignments
   // here would create order-dependent simulation and sim/synth mismatch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state, counter and handshake outputs
   // NOTE: every signal driven here gets a default before the case, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_exec      = 1'b0;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_accept  = 1'b1;
               w_cnt_nxt = LAT_LOAD;
               if (LAT_LOAD == 4'd0) begin
                  // Zero latency: the access executes on the accept edge.
                  w_state_nxt = ST_RESP;
                  w_exec      = 1'b1;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            // Counter hits zero on this edge: execute and present response.
            if (r_cnt <= 4'd1) begin
               w_cnt_nxt   = 4'd0;
               w_state_nxt = ST_RESP;
               w_exec      = 1'b1;
            end
         end
         ST_RESP: begin
            rsp_valid   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Capture the request payload on accept; ignored while not ready
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_size  <= 3'b000;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
      end else if (w_accept) begin
         r_we    <= req_we;
         r_size  <= req_size;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
      end
   end

   // With zero latency the execute edge is the accept edge, so the live
   // request is used; otherwise the captured copy is.
   assign w_op_we    = (LATENCY == 0) ? req_we    : r_we;
   assign w_op_size  = (LATENCY == 0) ? req_size  : r_size;
   assign w_op_addr  = (LATENCY == 0) ? req_addr  : r_addr;
   assign w_op_wdata = (LATENCY == 0) ? req_wdata : r_wdata;

   assign w_idx_full = w_op_addr[31:2];
   assign w_idx      = w_op_addr[IDX_W+1:2];
   assign w_lane     = w_op_addr[1:0];

   // Request legality: bad size, store-unsigned, misalignment, range
   always_comb begin
      w_err = 1'b0;
      case (w_op_size)
         3'b000:  w_err = 1'b0;
         3'b001:  w_err = w_op_addr[0];
         3'b010:  w_err = (w_lane != 2'b00);
         3'b100:  w_err = w_op_we;
         3'b101:  w_err = w_op_we | w_op_addr[0];
         default: w_err = 1'b1;
      endcase
      if (w_idx_full >= DEPTH_LIMIT) begin
         w_err = 1'b1;
      end
   end

   // Store lane steering: byte enables and replicated write data
   always_comb begin
      w_be          = 4'b0000;
      w_wdata_lanes = 32'd0;
      case (w_op_size[1:0])
         2'b00: begin
            w_be          = 4'b0001 << w_lane;
            w_wdata_lanes = {4{w_op_wdata[7:0]}};
         end
         2'b01: begin
            w_be          = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata_lanes = {2{w_op_wdata[15:0]}};
         end
         default: begin
            w_be          = 4'b1111;
            w_wdata_lanes = w_op_wdata;
         end
      endcase
   end

   assign w_rd_word = mem[w_idx];

   // Load lane selection and sign/zero extension
   always_comb begin
      w_byte = 8'd0;
      case (w_lane)
         2'd0: w_byte = w_rd_word[7:0];
         2'd1: w_byte = w_rd_word[15:8];
         2'd2: w_byte = w_rd_word[23:16];
         2'd3: w_byte = w_rd_word[31:24];
         default: w_byte = 8'd0;
      endcase
      w_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
      case (w_op_size)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b010:  w_load = w_rd_word;
         3'b100:  w_load = {24'd0, w_byte};
         3'b101:  w_load = {16'd0, w_half};
         default: w_load = 32'd0;
      endcase
   end

   // Commit only on a legal store at the execute edge, never while in
   // reset, so an in-flight store cut short by reset is dropped.
   assign w_mem_we = w_exec & w_op_we & ~w_err & reset;

   // Byte-lane write into the data array
   // NOTE: the array is intentionally not reset; contents must survive a
   // reset and clearing a RAM would prevent mapping it onto memory macros.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               mem[w_idx][8*i +: 8] <= w_wdata_lanes[8*i +: 8];
            end
         end
      end
   end

   // Response data/error register, held until the next execute
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else if (w_exec) begin
         rsp_rdata <= (w_err | w_op_we) ? 32'd0 : w_load;
         rsp_err   <= w_err;
      end
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the pipelined RISC-V core: it is the memory end of the core's load/store interface. It accepts one request at a time through a valid/ready handshake and performs RV32I byte, halfword and word accesses with lane steering and load sign/zero extension. It returns one response after a programmable number of wait cycles and flags bad requests instead of executing them. The core's hazard unit holds the memory-stage instruction until `rsp_valid`.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit words; word index = `req_addr[31:2]`.
- `LATENCY`, default 2: wait cycles between accept and response; legal range 0–15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low: asserted when 0.
- `req_valid`  in  1  request present; held with all payload until accepted.
- `req_ready`  out  1  responder can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  load result, extended; 0 for stores and errors.
- `rsp_err`  out  1  request rejected; qualified by `rsp_valid`.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. When `req_valid`=1, the request is accepted at the next edge and addr, we, size and wdata are captured. The 4-bit down-counter is loaded with `LATENCY`. Next state: WAIT if `LATENCY`>0, else RESP.
- WAIT: `req_ready`=0. The counter decrements each cycle. The state moves to RESP on the edge where the counter reaches 0.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. Requests are never accepted in WAIT or RESP.
- Access execution happens on the edge entering RESP: the store is committed to the array and the load result is registered into `rsp_rdata`/`rsp_err`.
- Error conditions; any one sets `rsp_err`=1, blocks the write, and forces `rsp_rdata`=0:
  - `req_size` is 011, 110 or 111.
  - Store with size 100 or 101.
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - Word index ≥ `DEPTH_WORDS`.
- Little-endian lanes.
  - Byte access uses lane `addr[1:0]`.
  - Halfword access uses lanes {`addr[1]`,0} and {`addr[1]`,1}.
  - Stores modify only the addressed lanes; the other bytes of the word are preserved.
- Loads.
  - b/h are sign-extended from bit 7/15.
  - bu/hu are zero-extended.
  - w is returned as stored.
- `rsp_rdata` and `rsp_err` hold their values until the next response is registered.
- Memory array has no reset; contents are undefined until written.
- Reset asserted in any state:
  - State goes to IDLE and the counter to 0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - An in-flight request is dropped; a store not yet committed is never written.
  - Array contents are preserved.
  - `req_ready` reads 1 while in reset.

## Timing
- Accept cycle = cycle 0 (`req_valid`&`req_ready` high).
- WAIT occupies cycles 1..`LATENCY`.
- `rsp_valid` is high in cycle `LATENCY`+1 only.
- `req_ready` returns high in cycle `LATENCY`+2. Peak throughput is one request per `LATENCY`+2 cycles.
- A load issued after a store to the same address returns the stored data, because the commit precedes the next accept.
- `req_valid` dropping after accept has no effect.
- Payload changes while `req_ready`=0 are ignored.
- `LATENCY`=0: accept in cycle 0, response in cycle 1.

## Test plan
- Reset: hold `reset`=0 for 3 cycles -> `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Word store/load, `LATENCY`=2:
  - sw 0x00000019 to 0x64 accepted in cycle 0 -> `rsp_valid` in cycle 3 only, `rsp_err`=0.
  - Then lw 0x64 -> `rsp_rdata`=0x00000019.
  - `req_ready`=0 in cycles 1–3.
- Byte lanes:
  - sw 0x11223344 to 0x10; sb 0xAB to 0x12 -> lw 0x10 returns 0x11AB3344.
  - lb 0x12 returns 0xFFFFFFAB; lbu 0x12 returns 0x000000AB.
- Halfword: sh 0x8001 to 0x22 -> lh 0x22 returns 0xFFFF8001; lhu 0x22 returns 0x00008001; lw 0x20 keeps lanes 0–1 unchanged.
- Errors:
  - lw 0x66 -> `rsp_err`=1, `rsp_rdata`=0.
  - sw to 0x100 (index 64) -> `rsp_err`=1, and a following in-range read elsewhere confirms no aliasing write.
  - Size 011 -> `rsp_err`=1.
- Reset mid-operation: sw 0xDEADBEEF to 0x30 over old value 0x12345678; pulse `reset` low in cycle 1 -> no `rsp_valid`; a subsequent lw 0x30 returns 0x12345678.
